// File: rtl/evt2_decoder.sv
// evt2_decoder: EVT 2.0 raw word stream to x/y/p/t events with timestamp extension.
// Define EVT_DECODER_STATS_EN to add saturating cnt_cd / cnt_drop counters.
module evt2_decoder #(
    parameter int          X_BITS = 16,
    parameter int          Y_BITS = 16,
    parameter int          T_BITS = 64,
    parameter int unsigned X_MAX  = 1279,
    parameter int unsigned Y_MAX  = 719
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       raw_data,
    input  logic              raw_valid,
    output logic              raw_ready,
    output logic [X_BITS-1:0] x_out,
    output logic [Y_BITS-1:0] y_out,
    output logic              p_out,
    output logic [T_BITS-1:0] t_out,
    output logic              push,
    output logic              synced
`ifdef EVT_DECODER_STATS_EN
    ,
    output logic [31:0]       cnt_cd,
    output logic [31:0]       cnt_drop
`endif
);
    localparam int EW = T_BITS > 34 ? T_BITS - 34 : 1;

    if (T_BITS < 34) begin : g_bad_t_bits
        $error("evt2_decoder: T_BITS must be >= 34");
    end

    typedef enum logic {SYNC, RUN} state_t;

    state_t           state, state_n;
    logic [27:0]      time_high;
    logic [EW-1:0]    epoch;
    logic [EW+33:0]   t_full;
    logic             acc, is_th, is_cd, in_range, do_push;

    assign raw_ready = !rst;
    assign synced    = state == RUN;

    always_comb begin
        acc      = raw_valid && raw_ready;
        is_th    = raw_data[31:28] == 4'h8;
        is_cd    = raw_data[31:29] == 3'b000;
        in_range = 32'(raw_data[21:11]) <= X_MAX && 32'(raw_data[10:0]) <= Y_MAX;
        do_push  = acc && is_cd && state == RUN && in_range;
        t_full   = {epoch, time_high, raw_data[27:22]};
        state_n  = acc && is_th ? RUN : state;
    end

    always_ff @(posedge clk)
        state <= rst ? SYNC : state_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            push      <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            p_out     <= 1'b0;
            t_out     <= '0;
            time_high <= '0;
            epoch     <= '0;
        end else begin
            push <= do_push;
            if (do_push) begin
                x_out <= X_BITS'(raw_data[21:11]);
                y_out <= Y_BITS'(raw_data[10:0]);
                p_out <= raw_data[28];
                t_out <= t_full[T_BITS-1:0];
            end
            // A decreasing TIME_HIGH means the sensor's 34-bit counter wrapped.
            if (acc && is_th) begin
                time_high <= raw_data[27:0];
                if (state == RUN && raw_data[27:0] < time_high)
                    epoch <= epoch + EW'(1);
            end
        end
    end

`ifdef EVT_DECODER_STATS_EN
    logic drop;

    assign drop = acc && !is_th && !do_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_cd   <= '0;
            cnt_drop <= '0;
        end else begin
            if (do_push && ~&cnt_cd)
                cnt_cd <= cnt_cd + 32'd1;
            if (drop && ~&cnt_drop)
                cnt_drop <= cnt_drop + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_evt2_decoder.sv
// tb_evt2_decoder: directed spec scenarios plus random stream against an arithmetic event model.
module tb_evt2_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] raw_data = '0;
    logic        raw_valid = 1'b0;
    logic        raw_ready;
    logic [15:0] x_out, y_out;
    logic        p_out, push, synced;
    logic [63:0] t_out;
`ifdef EVT_DECODER_STATS_EN
    logic [31:0] cnt_cd, cnt_drop;
`endif

    evt2_decoder dut (
        .clk(clk), .rst(rst), .raw_data(raw_data), .raw_valid(raw_valid), .raw_ready(raw_ready),
        .x_out(x_out), .y_out(y_out), .p_out(p_out), .t_out(t_out), .push(push), .synced(synced)
`ifdef EVT_DECODER_STATS_EN
        , .cnt_cd(cnt_cd), .cnt_drop(cnt_drop)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    bit              m_synced;
    int unsigned     m_th;
    longint unsigned m_epoch;
    bit              e_push, e_p;
    int unsigned     e_x, e_y;
    longint unsigned e_t;
    int unsigned     e_cd, e_drop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_synced = 0; m_th = 0; m_epoch = 0;
        e_push = 0; e_p = 0; e_x = 0; e_y = 0; e_t = 0; e_cd = 0; e_drop = 0;
    endtask

    // Reference: the event's absolute time is epoch*2^34 + time_high*64 + ts_lsb.
    task automatic model_word(input logic [31:0] w);
        int unsigned typ, x, y, lsb;
        typ = w[31:28]; lsb = w[27:22]; x = w[21:11]; y = w[10:0];
        e_push = 0;
        if (typ == 8) begin
            if (m_synced && w[27:0] < m_th) m_epoch++;
            m_th = w[27:0];
            m_synced = 1;
        end else if (typ <= 1 && m_synced && x <= 1279 && y <= 719) begin
            e_push = 1; e_x = x; e_y = y; e_p = typ[0];
            e_t = (m_epoch << 34) + longint'(m_th) * 64 + lsb;
            if (e_cd != 32'hFFFF_FFFF) e_cd++;
        end else if (e_drop != 32'hFFFF_FFFF) e_drop++;
    endtask

    task automatic check_all();
        chk("push", 64'(push), 64'(e_push));
        chk("synced", 64'(synced), 64'(m_synced));
        chk("x_out", 64'(x_out), 64'(e_x));
        chk("y_out", 64'(y_out), 64'(e_y));
        chk("p_out", 64'(p_out), 64'(e_p));
        chk("t_out", t_out, e_t);
        chk("raw_ready", 64'(raw_ready), 64'(!rst));
`ifdef EVT_DECODER_STATS_EN
        chk("cnt_cd", 64'(cnt_cd), 64'(e_cd));
        chk("cnt_drop", 64'(cnt_drop), 64'(e_drop));
`endif
    endtask

    task automatic send(input logic [31:0] w, input bit v);
        raw_data = w; raw_valid = v;
        @(posedge clk);
        if (v) model_word(w);
        else e_push = 0;
        #1;
        raw_valid = 1'b0;
        check_all();
    endtask

    task automatic do_reset(input logic [31:0] w);
        rst = 1'b1; raw_data = w; raw_valid = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        check_all();
        rst = 1'b0; raw_valid = 1'b0;
    endtask

    function automatic logic [31:0] cd(input bit p, input int unsigned lsb, x, y);
        return {3'b000, p, 6'(lsb), 11'(x), 11'(y)};
    endfunction

    function automatic logic [31:0] th(input int unsigned ts);
        return {4'h8, 28'(ts)};
    endfunction

    initial begin
        model_reset();
        do_reset(cd(1, 0, 1, 1));
        do_reset(32'h0);
        // 1: CD before time base
        send(cd(1, 3, 5, 7), 1);
        chk("t1_nopush", 64'(push), 64'd0);
        // 2: first TIME_HIGH then CD
        send(th(28'h0000123), 1);
        send(cd(1, 6'h2A, 100, 200), 1);
        chk("t2_t", t_out, 64'h48EA);
        send(32'h0, 0);
        chk("t2_hold_t", t_out, 64'h48EA);
        // 3: wrap detection
        send(th(28'hFFFFFFF), 1);
        send(th(28'h0000001), 1);
        send(cd(0, 0, 0, 0), 1);
        chk("t3_t", t_out, 64'h4_0000_0040);
        // 4: range boundaries and other type
        send(cd(1, 1, 1280, 0), 1);
        send(cd(1, 1, 0, 720), 1);
        send(32'hA123_4567, 1);
        send(cd(0, 9, 1279, 719), 1);
        chk("t4_edge_x", 64'(x_out), 64'd1279);
        // 5: back-to-back
        for (int i = 0; i < 8; i++) send(cd(i[0], i * 7, i * 150, i * 80), 1);
        // 6: reset right after a CD accept
        send(cd(1, 2, 3, 4), 1);
        do_reset(cd(1, 5, 6, 7));
        chk("t6_synced", 64'(synced), 64'd0);
        send(cd(1, 5, 6, 7), 1);
        // random stream
        for (int i = 0; i < 600; i++) begin
            int unsigned r;
            logic [31:0] w;
            r = $urandom_range(0, 99);
            if (r < 40) w = cd($urandom_range(0, 1), $urandom_range(0, 63),
                               $urandom_range(0, 1400), $urandom_range(0, 800));
            else if (r < 55) w = th($urandom_range(0, 1) ? $urandom : $urandom_range(0, 4));
            else if (r < 65) w = {4'($urandom_range(2, 15)), 28'($urandom)};
            else if (r < 80) w = cd($urandom_range(0, 1), $urandom_range(0, 63),
                                    $urandom_range(1270, 1290), $urandom_range(710, 730));
            else w = $urandom;
            if (r == 99) do_reset(w);
            else send(w, $urandom_range(0, 9) != 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
